// File: rtl/gcd_arb_pkg.sv
// gcd_arb_pkg: shared types and helpers for the GCD arbiter slice.
//   gcd_arb_state_e : arbiter FSM states (IDLE, ISSUE, BUSY, RESP)
//   zero_gcd()      : local result for a job with at least one zero operand
package gcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP
  } gcd_arb_state_e;

  // Widest operand the zero helper handles; callers size-cast in and out.
  localparam int unsigned GCD_ARB_MAX_W = 64;

  // gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0. Only meaningful when a or b is zero.
  function automatic logic [GCD_ARB_MAX_W-1:0] zero_gcd(
    input logic [GCD_ARB_MAX_W-1:0] a,
    input logic [GCD_ARB_MAX_W-1:0] b
  );
    return (a == '0) ? b : a;
  endfunction

endpackage

// File: rtl/gcd_arbiter_picker.sv
// gcd_rr_picker: combinational round-robin priority picker.
//   req_valid : per-requester request vector
//   rr_ptr    : highest-priority index this round (inclusive)
//   grant     : first valid index at or after rr_ptr, wrapping N_REQ-1 -> 0
//   any_valid : at least one request present (grant meaningful only then)
module gcd_rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDW-1:0]   rr_ptr,
  output logic [IDW-1:0]   grant,
  output logic             any_valid
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = IDW'((32'(rr_ptr) + i) % N_REQ);
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        grant     = idx;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin scheduler sharing one iterative GCD engine
// between N_REQ requesters. One job in flight at a time.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot)
//   req_a, req_b        : flattened operands, requester i at [i*W +: W]
//   resp_valid/ready    : result handshake; resp_id/resp_gcd/resp_err payload
//   eng_start           : one-cycle start pulse to the engine
//   eng_a, eng_b        : engine operands, held from start until done
//   eng_done, eng_gcd   : engine completion and result
// Optional feature: define GCD_ARB_TIMEOUT_EN to enable the BUSY watchdog
// (TIMEOUT_CYCLES); otherwise resp_err is tied 0 and BUSY waits forever.
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned W              = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [W-1:0]             resp_gcd,
  output logic                     resp_err,
  output logic                     eng_start,
  output logic [W-1:0]             eng_a,
  output logic [W-1:0]             eng_b,
  input  logic                     eng_done,
  input  logic [W-1:0]             eng_gcd
);

  localparam int unsigned IDW = $clog2(N_REQ);

  gcd_arb_state_e state_q, state_d;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant;
  logic             any_valid;
  logic [N_REQ-1:0] ready_raw;
  logic             accept;
  logic [W-1:0]     a_sel, b_sel;
  logic             job_zero;
  logic             timeout_hit;

  gcd_rr_picker #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // Operand mux with constant slice bounds per requester.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant == IDW'(i)) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
    end
  end

  assign job_zero = (a_sel == '0) || (b_sel == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ready_raw  = '0;
    accept     = 1'b0;
    eng_start  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          accept           = 1'b1;
          ready_raw[grant] = 1'b1;
          state_d          = job_zero ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        eng_start = 1'b1;
        state_d   = BUSY;
      end
      BUSY: begin
        if (eng_done || timeout_hit) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The grant is combinational from req_valid; masking with rst_n keeps
  // req_ready low while reset is held even if requesters are already valid.
  assign req_ready = ready_raw & {N_REQ{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      eng_a    <= '0;
      eng_b    <= '0;
      resp_id  <= '0;
      resp_gcd <= '0;
    end else if (accept) begin
      resp_id <= grant;
      rr_ptr  <= (grant == IDW'(N_REQ - 1)) ? '0 : grant + 1'b1;
      if (job_zero) begin
        resp_gcd <= W'(zero_gcd(GCD_ARB_MAX_W'(a_sel), GCD_ARB_MAX_W'(b_sel)));
      end else begin
        // Zero jobs never reach the engine, so its operands only move here.
        eng_a    <= a_sel;
        eng_b    <= b_sel;
        resp_gcd <= '0;
      end
    end else if (state_q == BUSY) begin
      if (eng_done)         resp_gcd <= eng_gcd;
      else if (timeout_hit) resp_gcd <= '0;
    end
  end

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;

  // Counts completed BUSY cycles; fires on the TIMEOUT_CYCLES-th BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           wd_cnt <= '0;
    else if (state_q == ISSUE)            wd_cnt <= '0;
    else if (state_q == BUSY && !eng_done) wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout_hit = (state_q == BUSY) && !eng_done &&
                       (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           resp_err <= 1'b0;
    else if (accept)      resp_err <= 1'b0;
    else if (timeout_hit) resp_err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;

  // Watchdog compiled out; the parameter stays so both builds share one port list.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
module tb_gcd_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;
  localparam int NEVER = 1 << 30;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           resp_valid, resp_ready;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_gcd;
  logic           resp_err, eng_start;
  logic [W-1:0]   eng_a, eng_b;
  logic           eng_done;
  logic [W-1:0]   eng_gcd;

  gcd_arbiter #(
    .N_REQ          (N),
    .W              (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_gcd   (resp_gcd),
    .resp_err   (resp_err),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_done   (eng_done),
    .eng_gcd    (eng_gcd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // requesters
  logic [N-1:0] pend;
  logic [W-1:0] pa [N];
  logic [W-1:0] pb [N];

  // transaction-level model: one job record plus timestamps
  int           rr;
  bit           m_act, m_zero, m_err;
  int           m_id, t_acc, resp_at;
  logic [W-1:0] m_a, m_b, m_g;
  int           last_grant;

  // engine model
  bit           e_done;
  logic [W-1:0] e_res;
  int           e_cnt;
  int           e_lat_min = 1;
  int           e_lat_max = 8;
  bit           e_hang = 1'b0;

  // observations
  int           n_start, acc_cyc;
  bit           prev_rv, s_rv;
  int           grant_log[$];
  int           lat_log[$];
  logic [W-1:0] gcd_log[$];
  int           id_log[$];
  int           err_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = pend[i];
      req_a[i*W +: W]  = pa[i];
      req_b[i*W +: W]  = pb[i];
    end
  endtask

  task automatic arm(input int i);
    logic [W-1:0] f, x, y;
    f = $urandom_range(40, 1);
    x = $urandom_range(300, 0);
    y = $urandom_range(300, 0);
    if ($urandom_range(9, 0) == 0) x = 0;
    if ($urandom_range(9, 0) == 0) y = 0;
    pa[i] = f * x; pb[i] = f * y; pend[i] = 1'b1;
  endtask

  // One clock cycle, entered at a falling edge.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int w;
    bit exp_rv;
    drive_reqs();
    #1;
    exp_rdy = '0;
    w = -1;
    if (!m_act) begin
      w = rr_pick(req_valid, rr);
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    exp_rv = m_act && (cyc >= resp_at);
    chk("req_ready", req_ready, exp_rdy);
    chk("eng_start", eng_start, m_act && !m_zero && (cyc == t_acc + 1));
    chk("resp_valid", resp_valid, exp_rv);
    if (exp_rv) begin
      chk("resp_id", resp_id, m_id);
      chk("resp_gcd", resp_gcd, m_g);
      chk("resp_err", resp_err, m_err);
    end
    if (m_act && !m_zero && cyc > t_acc) begin
      chk("eng_a", eng_a, m_a);
      chk("eng_b", eng_b, m_b);
    end
    // observations for directed checks
    s_rv = resp_valid;
    if (eng_start) n_start++;
    for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
    if (req_ready != '0) acc_cyc = cyc;
    if (s_rv && !prev_rv) lat_log.push_back(cyc - acc_cyc);
    prev_rv = s_rv;
    if (s_rv && resp_ready) begin
      gcd_log.push_back(resp_gcd); id_log.push_back(resp_id); err_log.push_back(resp_err);
    end
    // model advance across the coming rising edge
    last_grant = -1;
    if (!m_act) begin
      if (w >= 0) begin
        m_act = 1'b1; m_id = w; m_a = pa[w]; m_b = pb[w];
        rr = (w + 1) % N; t_acc = cyc; m_err = 1'b0; last_grant = w;
        m_zero = (m_a == 0) || (m_b == 0);
        if (m_zero) begin
          resp_at = cyc + 1; m_g = (m_a == 0) ? m_b : m_a;
        end else begin
          resp_at = NEVER;
        end
      end
    end else if (cyc >= resp_at) begin
      if (resp_ready) m_act = 1'b0;
    end else if (!m_zero && cyc >= t_acc + 2) begin
      if (eng_done) begin
        resp_at = cyc + 1; m_g = gcd_ref(m_a, m_b); m_err = 1'b0;
      end
`ifdef GCD_ARB_TIMEOUT_EN
      else if (cyc == t_acc + 2 + TO - 1) begin
        resp_at = cyc + 1; m_g = '0; m_err = 1'b1;
      end
`endif
    end
    // engine advance
    if (eng_start) begin
      e_done = 1'b0;
      e_cnt  = e_hang ? -1 : int'($urandom_range(e_lat_max, e_lat_min));
      e_res  = gcd_ref(eng_a, eng_b);
    end else if (e_cnt > 0) begin
      e_cnt--;
      if (e_cnt == 0) e_done = 1'b1;
    end
    if (last_grant >= 0) pend[last_grant] = 1'b0;
    @(negedge clk);
    cyc++;
    eng_done = e_done;
    eng_gcd  = e_done ? e_res : W'($urandom);
  endtask

  task automatic do_reset_check();
    rst_n = 1'b0;
    drive_reqs();
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_gcd", resp_gcd, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_a", eng_a, 0);
    chk("rst_eng_b", eng_b, 0);
    m_act = 1'b0; rr = 0; e_done = 1'b0; e_cnt = 0; eng_done = 1'b0; prev_rv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_quiet(input string name, input int budget);
    int n;
    n = 0;
    while ((m_act || pend != '0) && n < budget) begin
      step(); n++;
    end
    chk({name, "_quiet"}, (m_act || pend != '0), 0);
  endtask

  task automatic wait_rv(input string name, input int budget);
    int n;
    n = 0;
    s_rv = 1'b0;
    while (!s_rv && n < budget) begin
      step(); n++;
    end
    chk({name, "_seen"}, s_rv, 1);
  endtask

  initial begin
    int exp_ord[5];
    int za[3], zb[3], zexp[3];
    int n, held;

    exp_ord = '{0, 1, 2, 3, 0};
    za = '{0, 9, 0}; zb = '{25, 0, 0}; zexp = '{25, 9, 0};
    rst_n = 1'b1; resp_ready = 1'b1; eng_done = 1'b0; eng_gcd = '0;
    n_start = 0; acc_cyc = 0; prev_rv = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1; pa[i] = W'(i + 3); pb[i] = W'(2 * i + 5);
    end
    #1;
    do_reset_check();
    pend = '0;

    // single job (14,161) -> 7
    gcd_log.delete(); id_log.delete(); n_start = 0;
    pend[0] = 1'b1; pa[0] = 14; pb[0] = 161;
    run_quiet("t1", 60);
    chk("t1_count", gcd_log.size(), 1);
    if (gcd_log.size() > 0) begin
      chk("t1_gcd", gcd_log[0], 7);
      chk("t1_id", id_log[0], 0);
    end
    chk("t1_starts", n_start, 1);

    // contention from rr_ptr=0
    do_reset_check();
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1; pa[i] = W'(6 * (i + 1)); pb[i] = W'(4 * (i + 2));
    end
    n = 0;
    while (grant_log.size() < 5 && n < 300) begin
      step(); n++;
      if (grant_log.size() < 5) pend = '1;
    end
    chk("t2_grants", grant_log.size() >= 5, 1);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("t2_order", grant_log[k], exp_ord[k]);
    run_quiet("t2", 300);

    // zero operands resolved locally
    n_start = 0; gcd_log.delete(); lat_log.delete();
    for (int k = 0; k < 3; k++) begin
      pend[2] = 1'b1; pa[2] = W'(za[k]); pb[2] = W'(zb[k]);
      run_quiet("t3", 20);
      chk("t3_gcd", gcd_log.size() > k ? gcd_log[k] : 'x, zexp[k]);
      chk("t3_lat", lat_log.size() > k ? lat_log[k] : -1, 1);
    end
    chk("t3_starts", n_start, 0);

    // backpressure
    resp_ready = 1'b0;
    pend[1] = 1'b1; pa[1] = 5; pb[1] = 15;
    wait_rv("t4", 40);
    pend[0] = 1'b1; pa[0] = 21; pb[0] = 35;
    pend[3] = 1'b1; pa[3] = 8; pb[3] = 12;
    held = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (s_rv) held++;
    end
    chk("t4_held", held, 10);
    resp_ready = 1'b1;
    run_quiet("t4", 200);

    // reset while BUSY
    e_lat_min = 20; e_lat_max = 20;
    pend[3] = 1'b1; pa[3] = 12; pb[3] = 18;
    n = 0;
    while (!(m_act && !m_zero && cyc >= t_acc + 4) && n < 20) begin
      step(); n++;
    end
    chk("t5_busy", m_act && !m_zero && cyc >= t_acc + 4, 1);
    #2;
    do_reset_check();
    e_lat_min = 1; e_lat_max = 8;
    grant_log.delete();
    pend[1] = 1'b1; pa[1] = 27; pb[1] = 45;
    pend[3] = 1'b1; pa[3] = 10; pb[3] = 4;
    run_quiet("t5", 200);
    chk("t5_first", grant_log.size() > 0 ? grant_log[0] : -1, 1);

`ifdef GCD_ARB_TIMEOUT_EN
    // watchdog
    e_hang = 1'b1; lat_log.delete(); resp_ready = 1'b0;
    pend[0] = 1'b1; pa[0] = 6; pb[0] = 4;
    wait_rv("t6", 60);
    chk("t6_err", resp_err, 1);
    chk("t6_gcd", resp_gcd, 0);
    chk("t6_lat", lat_log.size() > 0 ? lat_log[0] : -1, TO + 2);
    e_done = 1'b1; e_res = 99;
    for (int k = 0; k < 3; k++) step();
    resp_ready = 1'b1;
    e_hang = 1'b0;
    run_quiet("t6", 40);
    pend[2] = 1'b1; pa[2] = 50; pb[2] = 75;
    run_quiet("t6b", 60);
`endif

    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(3, 0) == 0) arm(i);
        else if (pend[i] && $urandom_range(39, 0) == 0) pend[i] = 1'b0;
      end
      resp_ready = ($urandom_range(9, 0) < 7);
      step();
    end
    resp_ready = 1'b1;
    run_quiet("rand", 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
